// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle: producer valid/ready/data, FIFO full flag and write strobe.
// slave = arbiter side; master = producers + FIFO side (bench drives it).
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          write_en;
  logic [DATA_WIDTH-1:0]         write_data_in;

  modport master (
    output req_valid,
    output req_data,
    output full,
    input  req_ready,
    input  write_en,
    input  write_data_in
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  full,
    output req_ready,
    output write_en,
    output write_data_in
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded scheduler for the FIFO write port.
// Ports: write_clk, reset (sync, high), bus (slave), grant_valid/grant_id/write_count.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                 write_clk,
  input  logic                 reset,
  fifo_write_arbiter_if.slave  bus,
  output logic                 grant_valid,
  output logic [2:0]           grant_id,
  output logic [15:0]          write_count
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam logic [4:0] LAST = 5'(MAX_BURST - 1);
  localparam logic [2:0] RST_ID = 3'(NUM_REQ - 1);

  state_t                state_q;
  logic                  gv_q;
  logic [2:0]            gid_q;
  logic [2:0]            gid_d;
  logic [4:0]            burst_cnt_q;
  logic [15:0]           wcnt_q;

  logic                  g_valid;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  xfer;
  logic                  hi_found;
  logic                  lo_found;
  logic [2:0]            hi_id;
  logic [2:0]            lo_id;

  // Round-robin pick: lowest valid index above the last grant,
  // otherwise wrap to the lowest valid index overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i]) begin
        if (!hi_found && (3'(i) > gid_q)) begin
          hi_found = 1'b1;
          hi_id    = 3'(i);
        end
        if (!lo_found) begin
          lo_found = 1'b1;
          lo_id    = 3'(i);
        end
      end
    end
    gid_d = hi_found ? hi_id : lo_id;
  end

  // Granted requester's valid/data, and the write-side outputs.
  // Reset gates the strobe so a word in a reset cycle is never written.
  always_comb begin
    g_valid       = 1'b0;
    g_data        = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == 3'(i)) begin
        g_valid = bus.req_valid[i];
        g_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        bus.req_ready[i] = (state_q == BURST) && !bus.full && !reset;
      end
    end
    xfer              = (state_q == BURST) && g_valid && !bus.full && !reset;
    bus.write_en      = xfer;
    bus.write_data_in = xfer ? g_data : '0;
  end

  always_ff @(posedge write_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gv_q        <= 1'b0;
      gid_q       <= RST_ID;
      burst_cnt_q <= '0;
      wcnt_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            state_q     <= BURST;
            gv_q        <= 1'b1;
            gid_q       <= gid_d;
            burst_cnt_q <= '0;
          end
        end
        BURST: begin
          if (!g_valid) begin
            state_q <= IDLE;
            gv_q    <= 1'b0;
          end else if (xfer) begin
            wcnt_q      <= wcnt_q + 16'd1;
            burst_cnt_q <= burst_cnt_q + 5'd1;
            if (burst_cnt_q == LAST) begin
              state_q <= IDLE;
              gv_q    <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign grant_valid = gv_q;
  assign grant_id    = gid_q;
  assign write_count = wcnt_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter.
// Producer queues feed the bus; expected writes are queued in grant order.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        reset;
  logic        grant_valid;
  logic [2:0]  grant_id;
  logic [15:0] write_count;

  fifo_write_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  fifo_write_arbiter #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .MAX_BURST(4)
  ) dut (
    .write_clk  (clk),
    .reset      (reset),
    .bus        (bus),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .write_count(write_count)
  );

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb [$];
  exp_t       e;
  logic [7:0] src [4][$];
  logic [3:0] en;
  logic [3:0] fire;
  int         checks;
  int         errors;
  logic [2:0] prev_gid;
  logic       prev_gv;
  logic       prev_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int id, input logic [7:0] d, input bit expect_it);
    src[id].push_back(d);
    if (expect_it) sb.push_back('{id: 3'(id), data: d});
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // Producers: retire a word that handshook, then present the next one.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++)
      if (fire[i] && src[i].size() > 0) void'(src[i].pop_front());
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = en[i] && (src[i].size() > 0);
      if (src[i].size() > 0) bus.req_data[i*8 +: 8] = src[i][0];
      else bus.req_data[i*8 +: 8] = 8'h00;
    end
  end

  // Mid-cycle monitor: scoreboard pops plus invariant checks.
  always @(negedge clk) begin
    fire = bus.req_valid & bus.req_ready;
    if (bus.write_en) begin
      if (sb.size() == 0) chk("sb_extra", 1, 0);
      else begin
        e = sb.pop_front();
        chk("wdata", 32'(bus.write_data_in), 32'(e.data));
        chk("wid", 32'(grant_id), 32'(e.id));
      end
    end else begin
      chk("wdata_zero", 32'(bus.write_data_in), 0);
    end
    if (bus.full) chk("wen_full", 32'(bus.write_en), 0);
    chk("rdy_other", 32'(bus.req_ready & ~(4'b0001 << grant_id)), 0);
    if (!prev_rst && grant_id != prev_gid)
      chk("gid_via_idle", 32'(prev_gv), 0);
    prev_gid = grant_id;
    prev_gv  = grant_valid;
    prev_rst = reset;
  end

  int pat [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    checks   = 0;
    errors   = 0;
    fire     = '0;
    en       = '0;
    prev_rst = 1'b1;
    prev_gv  = 1'b0;
    prev_gid = '0;
    reset    = 1'b1;
    bus.full      = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset with every requester valid.
    en = 4'hF;
    for (int i = 0; i < 4; i++) push(i, 8'hEE, 1'b0);
    repeat (2) begin
      tick();
      @(negedge clk);
      chk("rst_gv", 32'(grant_valid), 0);
      chk("rst_wen", 32'(bus.write_en), 0);
      chk("rst_rdy", 32'(bus.req_ready), 0);
      chk("rst_gid", 32'(grant_id), 3);
      chk("rst_wcnt", 32'(write_count), 0);
    end
    tick();
    for (int i = 0; i < 4; i++) src[i].delete();
    en    = '0;
    reset = 1'b0;

    // Single requester streaming 8 words.
    tick();
    for (int n = 0; n < 8; n++) push(2, 8'(8'h10 + n), 1'b1);
    en = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t2_wen", 32'(bus.write_en), 32'(pat[c]));
      if (c == 1) begin
        chk("t2_gv", 32'(grant_valid), 1);
        chk("t2_gid", 32'(grant_id), 2);
      end
    end
    drain(20);
    chk("t2_wcnt", 32'(write_count), 8);
    en = '0;

    // Round-robin with all requesters busy.
    do_reset();
    for (int n = 0; n < 4; n++) push(0, 8'(8'h10 + n), 1'b1);
    for (int i = 1; i < 4; i++)
      for (int n = 0; n < 4; n++) push(i, 8'((i + 1) * 16 + n), 1'b1);
    for (int n = 4; n < 8; n++) push(0, 8'(8'h10 + n), 1'b1);
    en = 4'hF;
    drain(100);
    chk("t3_wcnt", 32'(write_count), 20);
    en = '0;

    // Full stall after two transfers of requester 1.
    do_reset();
    for (int n = 0; n < 4; n++) push(1, 8'(8'h60 + n), 1'b1);
    for (int n = 0; n < 2; n++) push(3, 8'(8'h70 + n), 1'b1);
    en = 4'b1010;
    repeat (3) tick();
    bus.full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_wen", 32'(bus.write_en), 0);
      chk("t4_rdy1", 32'(bus.req_ready[1]), 0);
      chk("t4_hold", 32'(bus.req_data[15:8]), 32'h62);
      chk("t4_gv", 32'(grant_valid), 1);
      chk("t4_gid", 32'(grant_id), 1);
    end
    tick();
    bus.full = 1'b0;
    drain(40);
    chk("t4_wcnt", 32'(write_count), 6);
    en = '0;

    // Early burst end when requester 0 drops valid.
    do_reset();
    for (int n = 0; n < 2; n++) push(0, 8'(8'h80 + n), 1'b1);
    for (int n = 0; n < 4; n++) push(3, 8'(8'h90 + n), 1'b1);
    en = 4'b1001;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("t5_end_wen", 32'(bus.write_en), 0);
    chk("t5_end_gv", 32'(grant_valid), 1);
    @(negedge clk);
    chk("t5_idle_gv", 32'(grant_valid), 0);
    @(negedge clk);
    chk("t5_next_gv", 32'(grant_valid), 1);
    chk("t5_next_gid", 32'(grant_id), 3);
    drain(40);
    chk("t5_wcnt", 32'(write_count), 6);
    en = '0;

    // Reset during the third transfer of requester 2.
    do_reset();
    for (int n = 0; n < 4; n++) push(2, 8'(8'hA0 + n), n < 2);
    en = 4'b0100;
    repeat (3) tick();
    reset = 1'b1;
    push(0, 8'hB0, 1'b1);
    sb.push_back('{id: 3'd2, data: 8'hA2});
    sb.push_back('{id: 3'd2, data: 8'hA3});
    en = 4'b0101;
    @(negedge clk);
    chk("t6_rst_wen", 32'(bus.write_en), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_idle_gv", 32'(grant_valid), 0);
    chk("t6_idle_wcnt", 32'(write_count), 0);
    @(negedge clk);
    chk("t6_gv", 32'(grant_valid), 1);
    chk("t6_gid", 32'(grant_id), 0);
    drain(40);
    chk("t6_wcnt", 32'(write_count), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
Write-side scheduler that shares the single write port of asynchronous_fifo among NUM_REQ producers in the write_clk domain. Round-robin grants with bounded bursts; the granted producer's data goes straight onto write_data_in/write_en. Flow control comes from the FIFO's write-domain full flag. Read side and clock crossing are untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, payload width; matches FIFO write_data_in
MAX_BURST, 4, max transfers per grant before forced rotation (1..16)

Ports:
write_clk  input  1  write-domain clock; all logic on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester data valid
req_data  input  NUM_REQ*DATA_WIDTH  packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept (combinational)
full  input  1  FIFO full, write_clk domain
write_en  output  1  FIFO write strobe (combinational)
write_data_in  output  DATA_WIDTH  FIFO write data (combinational mux)
grant_valid  output  1  registered; high in BURST
grant_id  output  3  registered; current/last granted index
write_count  output  16  registered; total accepted writes, wraps at 2^16

Behaviour:
- Reset (sampled at posedge write_clk while reset=1): state=IDLE, grant_valid=0, grant_id=NUM_REQ-1 (requester 0 has first priority), burst_cnt=0, write_count=0. Combinationally req_ready=0, write_en=0, write_data_in=0. Reset mid-burst aborts the grant at that edge; the data word in that cycle is not counted as accepted.
- States: IDLE, BURST.
- IDLE: if any req_valid, pick the first valid index scanning grant_id+1, +2, ... mod NUM_REQ. Register grant_id, set grant_valid=1, burst_cnt=0, go BURST. No transfer in IDLE (one-cycle arbitration bubble). No valid: stay IDLE, grant_id held.
- BURST, g=grant_id: req_ready[g] = !full; all other ready bits 0. Transfer when req_valid[g] && !full: write_en=1, write_data_in=req_data[g], write_count+1, burst_cnt+1.
- Burst end (next state IDLE, grant_valid=0 next cycle), whichever first: (a) a transfer with burst_cnt==MAX_BURST-1; (b) req_valid[g]=0 in a BURST cycle. full=1 with req_valid[g]=1 stalls: no transfer, burst_cnt held, stay BURST.
- write_en is never high when full=1. It is never high in IDLE.
- write_data_in = 0 whenever write_en=0.
- A single requester valid continuously at max rate gets MAX_BURST writes, 1 idle cycle, and repeats. Throughput is MAX_BURST/(MAX_BURST+1).
- write_count wraps 0xFFFF→0x0000 with no flag.
- req_valid of non-granted requesters is ignored. They must hold data/valid until their own ready (standard valid/ready; a requester must not drop valid while stalled by full, otherwise rule (b) ends the burst).

Test Plan:
- Reset: assert reset 2 cycles with all req_valid=1 -> grant_valid=0, write_en=0, req_ready=0, grant_id=3, write_count=0 throughout.
- Single requester: req 2 streams 0x10..0x17 continuously, full=0 -> grant lands 1 cycle after valid. Writes 0x10-0x13, one bubble, then 0x14-0x17. write_count=8. req_ready[0,1,3] never high.
- Round-robin: all 4 valid continuously, full=0 -> grant order 0,1,2,3,0, 4 writes each, grant_id changes only through IDLE.
- Full stall: req 1 mid-burst after 2 transfers, full=1 for 5 cycles -> write_en=0, req_ready[1]=0, data held. After full drops, exactly 2 more writes, then rotation. write_count increases by 4 total.
- Early end: req 0 valid for 2 transfers, then drops with req 3 valid -> burst ends after 2 writes, IDLE 1 cycle, grant_id=3.
- Reset mid-burst: reset asserted during transfer 3 of req 2 -> that word is not counted. Next cycle is IDLE with write_count=0. After release, requester 0 is granted first.
